// File: rtl/serial_nibble_adder.sv
// Nibble-serial adder: sequences W-bit operands through an
// external 4-bit full adder, one nibble per cycle.
module serial_nibble_adder #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         c_in,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_c_in,
  input  logic [3:0]   add_s,
  input  logic         add_c_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t       state;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic         carry;
  logic [2:0]   idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= 3'd0;
      sum   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= op_a;
            b_r   <= op_b;
            carry <= c_in;
            idx   <= 3'd0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (idx == 3'(n)) sum[4*n +: 4] <= add_s;
          end
          carry <= add_c_out;
          idx   <= idx + 3'd1;
          if (idx == 3'(NIBBLES - 1)) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Adder operands are muxed from registered state only, so
  // bus changes on op_a/op_b mid-run cannot reach the result.
  always_comb begin
    add_a    = 4'd0;
    add_b    = 4'd0;
    add_c_in = 1'b0;
    if (state == RUN) begin
      add_c_in = carry;
      for (int n = 0; n < NIBBLES; n++) begin
        if (idx == 3'(n)) begin
          add_a = a_r[4*n +: 4];
          add_b = b_r[4*n +: 4];
        end
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign c_out     = carry;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed and back-to-back checks for serial_nibble_adder,
// with a behavioural 4-bit adder closing the loop.
module tb_serial_nibble_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] op_a, op_b;
  logic        c_in;
  logic [3:0]  add_a, add_b, add_s;
  logic        add_c_in, add_c_out;
  logic        out_valid, out_ready;
  logic [15:0] sum;
  logic        c_out;

  logic        iv1, ir1, ci1, ac1, aco1, ov1, or1, co1;
  logic [3:0]  a1, b1, aa1, ab1, as1, s1;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] seq;

  always #5 clk = ~clk;

  serial_nibble_adder #(.NIBBLES(4)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .c_in(c_in),
    .add_a(add_a), .add_b(add_b), .add_c_in(add_c_in),
    .add_s(add_s), .add_c_out(add_c_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out)
  );

  serial_nibble_adder #(.NIBBLES(1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(iv1), .in_ready(ir1),
    .op_a(a1), .op_b(b1), .c_in(ci1),
    .add_a(aa1), .add_b(ab1), .add_c_in(ac1),
    .add_s(as1), .add_c_out(aco1),
    .out_valid(ov1), .out_ready(or1),
    .sum(s1), .c_out(co1)
  );

  assign {add_c_out, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_c_in);
  assign {aco1, as1} = 5'(aa1) + 5'(ab1) + 5'(ac1);

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic accept(logic [15:0] a, logic [15:0] b, logic ci);
    int w;
    w = 0;
    while (!in_ready && w < 30) begin
      tick();
      w++;
    end
    op_a = a;
    op_b = b;
    c_in = ci;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    seq = 16'h0;
    while (!out_valid && lat < 30) begin
      if (!in_ready) seq = (seq << 4) | 16'(add_a);
      tick();
      lat++;
    end
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int lat, bad, c, n_acc, n_res, last_acc;
    logic [16:0] q[$];
    logic [16:0] exp_r;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[6] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op_a = 16'h0;
    op_b = 16'h0;
    c_in = 1'b0;
    iv1 = 1'b0;
    or1 = 1'b0;
    a1 = 4'h0;
    b1 = 4'h0;
    ci1 = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_add", {add_a, add_b, 3'd0, add_c_in}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].ci);
      wait_done(lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].s));
      chk($sformatf("vec%0d_cout", i), 32'(c_out), 32'(vecs[i].co));
      chk($sformatf("vec%0d_add_idle", i),
          {add_a, add_b, 3'd0, add_c_in}, 32'd0);
      if (i == 1) chk("add_a_seq", 32'(seq), 32'h4321);
      release_op();
      chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'd1);
    end

    // Stall in DONE while a new offer is on the bus
    accept(16'h1234, 16'h4321, 1'b1);
    wait_done(lat);
    op_a = 16'hAAAA;
    op_b = 16'h5555;
    c_in = 1'b1;
    in_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!out_valid || sum !== 16'h5556 || c_out !== 1'b0 || in_ready)
        bad++;
    end
    chk("hold_bad_cycles", 32'(bad), 32'd0);
    in_valid = 1'b0;
    release_op();
    chk("hold_release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("hold_no_accept", 32'(out_valid), 32'd0);

    // Reset on the second RUN cycle discards the operation
    accept(16'hFFFF, 16'hFFFF, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid) bad++;
    end
    chk("mid_rst_no_pulse", 32'(bad), 32'd0);
    accept(16'h00FF, 16'h0001, 1'b0);
    wait_done(lat);
    chk("post_rst_sum", 32'(sum), 32'h0100);
    chk("post_rst_cout", 32'(c_out), 32'd0);
    release_op();

    // Back-to-back with random operands
    out_ready = 1'b1;
    n_acc = 0;
    n_res = 0;
    last_acc = -1;
    c = 0;
    while (n_res < 100 && c < 2000) begin
      if (out_valid) begin
        exp_r = q.pop_front();
        chk($sformatf("b2b_%0d", n_res), 32'({c_out, sum}), 32'(exp_r));
        n_res++;
      end
      if (in_ready) begin
        if (n_acc < 100) begin
          op_a = 16'($urandom);
          op_b = 16'($urandom);
          c_in = 1'($urandom);
          in_valid = 1'b1;
          q.push_back(17'(op_a) + 17'(op_b) + 17'(c_in));
          if (last_acc >= 0)
            chk("b2b_spacing", 32'(c - last_acc), 32'd6);
          last_acc = c;
          n_acc++;
        end else begin
          in_valid = 1'b0;
        end
      end
      tick();
      c++;
    end
    chk("b2b_results", 32'(n_res), 32'd100);
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();

    // Single-nibble instance
    chk("n1_ready", 32'(ir1), 32'd1);
    a1 = 4'hF;
    b1 = 4'hF;
    ci1 = 1'b1;
    iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    lat = 0;
    while (!ov1 && lat < 30) begin
      tick();
      lat++;
    end
    chk("n1_lat", 32'(lat), 32'd1);
    chk("n1_sum", 32'(s1), 32'hF);
    chk("n1_cout", 32'(co1), 32'd1);
    or1 = 1'b1;
    tick();
    or1 = 1'b0;
    chk("n1_ready_after", 32'(ir1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_nibble_adder.md
SERIAL_NIBBLE_ADDER -- requirements
Module: serial_nibble_adder

Interface
REQ-001 SHALL have parameter NIBBLES, default 4; number of 4-bit digits per operand, legal range 1..8.
REQ-002 SHALL define W = 4*NIBBLES as the operand and result width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand set offered.
REQ-007 in_ready  output  1  block can accept an operand set.
REQ-008 op_a  input  W  operand A.
REQ-009 op_b  input  W  operand B.
REQ-010 c_in  input  1  initial carry.
REQ-011 add_a  output  4  nibble of A to the external combinational 4-bit full adder.
REQ-012 add_b  output  4  nibble of B to the external adder.
REQ-013 add_c_in  output  1  running carry to the external adder.
REQ-014 add_s  input  4  sum nibble returned by the external adder in the same cycle.
REQ-015 add_c_out  input  1  carry returned by the external adder in the same cycle.
REQ-016 out_valid  output  1  result available.
REQ-017 out_ready  input  1  consumer accepts the result.
REQ-018 sum  output  W  result.
REQ-019 c_out  output  1  final carry.

Function
REQ-020 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-021 IDLE: in_ready=1, out_valid=0; on in_valid=1, latch op_a, op_b and c_in into internal registers; clear nibble index idx to 0; go to RUN.
REQ-022 RUN: in_ready=0, out_valid=0; present add_a=A[4*idx+3:4*idx], add_b=B[4*idx+3:4*idx] and add_c_in=carry register, all combinationally from registered state.
REQ-023 RUN, each edge: write add_s into sum[4*idx+3:4*idx]; load add_c_out into the carry register; increment idx.
REQ-024 RUN SHALL exit to DONE on the edge where idx==NIBBLES-1; a run lasts exactly NIBBLES cycles.
REQ-025 DONE: out_valid=1; c_out = carry register; sum and c_out SHALL hold stable until out_ready=1.
REQ-026 DONE with out_ready=1 SHALL return to IDLE on that edge; in_ready becomes 1 on the next cycle.
REQ-027 Latency: acceptance at edge k makes out_valid=1 in the cycle following edge k+NIBBLES.
REQ-028 Minimum spacing between accepted operand sets SHALL be NIBBLES+2 cycles.
REQ-029 In IDLE and DONE, add_a, add_b and add_c_in SHALL be driven to 0.
REQ-030 op_a, op_b, c_in and in_valid SHALL be ignored outside IDLE; operand changes during RUN SHALL NOT affect the result.
REQ-031 Result arithmetic: {c_out,sum} == op_a + op_b + c_in, evaluated at W+1 bits, for all inputs.
REQ-032 Carry SHALL ripple nibble to nibble, including wrap of all-ones operands into c_out.
REQ-033 sum SHALL retain its last value in IDLE and is valid only while out_valid=1.

Reset
REQ-034 rst=1 at an edge SHALL force IDLE, idx=0, carry=0, sum=0, c_out=0.
REQ-035 During and after reset: in_ready=1, out_valid=0, add_* =0, from the cycle after the reset edge.
REQ-036 rst SHALL take priority over every handshake in every state.
REQ-037 rst asserted in RUN or DONE SHALL discard the operation in progress; no out_valid pulse may follow.

Verification
REQ-038 NIBBLES=4, op_a=0xFFFF, op_b=0x0001, c_in=0 -> sum=0x0000, c_out=1, out_valid 5 cycles after acceptance.
REQ-039 NIBBLES=4, op_a=0x1234, op_b=0x4321, c_in=1 -> sum=0x5556, c_out=0; per-cycle add_a sequence 4,3,2,1.
REQ-040 Hold out_ready=0 for 10 cycles in DONE -> out_valid, sum and c_out unchanged; in_ready=0; new in_valid ignored.
REQ-041 Assert rst on the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0; subsequent op 0x00FF+0x0001 -> 0x0100.
REQ-042 Back-to-back: in_valid and out_ready held at 1 -> accepts every 6 cycles (NIBBLES=4); 100 random operand sets match op_a+op_b+c_in.
REQ-043 NIBBLES=1, op_a=0xF, op_b=0xF, c_in=1 -> sum=0xF, c_out=1, out_valid 2 cycles after acceptance.
